// File: rtl/sum_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_arbiter_if
// Description : Bundle between the shared-adder arbiter, its clients and the
//               adder. Groups the per-client request/operand buses, the grant
//               status, and the adder operand/result path.
//               master : client side and adder (drives req, a_flat, b_flat,
//                        sum_out; observes gnt, owner, busy, result,
//                        sum_in_a, sum_in_b)
//               slave  : the arbiter itself
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_arbiter_if #(
    parameter int N_CLIENTS = 3,
    parameter int WIDTH     = 16,
    parameter int IDX_W     = 2
);
    logic [N_CLIENTS-1:0]       req;
    logic [N_CLIENTS*WIDTH-1:0] a_flat;
    logic [N_CLIENTS*WIDTH-1:0] b_flat;
    logic [N_CLIENTS-1:0]       gnt;
    logic [IDX_W-1:0]           owner;
    logic                       busy;
    logic [WIDTH-1:0]           result;
    logic [WIDTH-1:0]           sum_in_a;
    logic [WIDTH-1:0]           sum_in_b;
    logic [WIDTH-1:0]           sum_out;

    modport master (
        output req, a_flat, b_flat, sum_out,
        input  gnt, owner, busy, result, sum_in_a, sum_in_b
    );

    modport slave (
        input  req, a_flat, b_flat, sum_out,
        output gnt, owner, busy, result, sum_in_a, sum_in_b
    );
endinterface
`default_nettype wire

// File: rtl/sum_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sum_arbiter
// Description : Round-robin, grant-locking arbiter that time-shares one
//               combinational adder between N_CLIENTS sequential clients.
//               A grant is held until its owner drops req; on release the
//               grant hands off to the next requester on the same edge.
//               The owner's operands are muxed to the adder; the adder result
//               is broadcast back to every client.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - sum_arbiter_if.slave:
//                      req/a_flat/b_flat in from clients, sum_out in from the
//                      adder; gnt/owner/busy (registered), result,
//                      sum_in_a/sum_in_b (combinational) out
// Revision    : 1.0 - initial release
// ============================================================================
module sum_arbiter #(
    parameter int N_CLIENTS = 3,
    parameter int WIDTH     = 16,
    parameter int IDX_W     = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sum_arbiter_if.slave  bus
);

    // Request vector widened to the full index range so any IDX_W-bit index
    // selects a defined bit; nonexistent clients read as not requesting.
    localparam int c_PAD_W = 1 << IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_CLIENTS-1:0]  r_gnt;
    logic [N_CLIENTS-1:0]  w_gnt_nxt;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      w_owner_nxt;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_rr_nxt;

    logic [c_PAD_W-1:0]    w_req_pad;
    logic [IDX_W-1:0]      w_owner_inc;
    logic [IDX_W-1:0]      w_scan_base;
    logic                  w_release;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic [IDX_W:0]        w_cand;
    logic [N_CLIENTS-1:0]  w_pick_oh;
    logic [WIDTH-1:0]      w_sum_in_a;
    logic [WIDTH-1:0]      w_sum_in_b;

    always_comb begin
        w_req_pad                = '0;
        w_req_pad[N_CLIENTS-1:0] = bus.req;
    end

    assign w_owner_inc = (r_owner == IDX_W'(N_CLIENTS - 1)) ? '0 : r_owner + 1'b1;
    assign w_release   = (r_state == ST_OWNED) && !w_req_pad[r_owner];

    // When idle the scan starts at the round-robin pointer; on a release it
    // starts just past the owner. The releasing owner needs no explicit mask:
    // its req bit is already low, which is what made this a release.
    assign w_scan_base = (r_state == ST_OWNED) ? w_owner_inc : r_rr_ptr;

    // Circular first-set search. Iterating from the farthest offset down to
    // zero lets the nearest requester overwrite earlier hits.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            w_cand = {1'b0, w_scan_base} + (IDX_W + 1)'(i);
            if (w_cand >= (IDX_W + 1)'(N_CLIENTS)) begin
                w_cand = w_cand - (IDX_W + 1)'(N_CLIENTS);
            end
            if (w_req_pad[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_pick_oh = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            w_pick_oh[k] = (w_pick == IDX_W'(k));
        end
    end

    // Next-state / next-grant logic
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_OWNED;
                    w_gnt_nxt   = w_pick_oh;
                    w_owner_nxt = w_pick;
                end
            end
            ST_OWNED: begin
                // Locked while the owner keeps req high: no preemption.
                if (w_release) begin
                    w_rr_nxt = w_owner_inc;
                    if (w_found) begin
                        w_gnt_nxt   = w_pick_oh;
                        w_owner_nxt = w_pick;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Operand mux driven by the registered owner and the live operand buses,
    // so an owner may present new operands every cycle. Zero when idle,
    // which also makes the adder inputs drop immediately on reset.
    always_comb begin
        w_sum_in_a = '0;
        w_sum_in_b = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if ((r_state == ST_OWNED) && (r_owner == IDX_W'(k))) begin
                w_sum_in_a = bus.a_flat[k*WIDTH +: WIDTH];
                w_sum_in_b = bus.b_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.owner    = r_owner;
    assign bus.busy     = (r_state == ST_OWNED);
    assign bus.result   = bus.sum_out;
    assign bus.sum_in_a = w_sum_in_a;
    assign bus.sum_in_b = w_sum_in_b;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(r_gnt));

    a_gnt_matches_busy: assert property (@(posedge clk) disable iff (rst)
        ((r_gnt != '0) == (r_state == ST_OWNED)));

endmodule
`default_nettype wire

// File: tb/tb_sum_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_arbiter
// Description : Self-checking bench for sum_arbiter. Acts as the adder,
//               keeps a behavioural reference of ownership, and runs
//               directed scenarios followed by randomized request traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_arbiter;
    localparam int N  = 3;
    localparam int W  = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    sum_arbiter_if #(.N_CLIENTS(N), .WIDTH(W), .IDX_W(IW)) bus ();

    sum_arbiter #(.N_CLIENTS(N), .WIDTH(W), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // The bench is the shared adder.
    assign bus.sum_out = bus.sum_in_a + bus.sum_in_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] op_a(input int k);
        return bus.a_flat[k*W +: W];
    endfunction

    function automatic logic [W-1:0] op_b(input int k);
        return bus.b_flat[k*W +: W];
    endfunction

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a_flat[k*W +: W] = a;
        bus.b_flat[k*W +: W] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference ----------------
    // Ownership is kept as (busy, owner index, round-robin start) and updated
    // from the rules: hold while owner requests; otherwise search the clients
    // in circular order from the start point, skipping the one releasing.
    bit m_busy;
    int m_owner;
    int m_rr;
    int m_start;
    int m_prev;
    bit m_was_busy;
    int m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_rr    = 0;
        end else if (!(m_busy && bus.req[m_owner])) begin
            m_was_busy = m_busy;
            m_prev     = m_owner;
            if (m_was_busy) m_rr = (m_prev + 1) % N;
            m_start = m_rr;
            m_busy  = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_k = (m_start + i) % N;
                if (!m_busy && bus.req[m_k] && !(m_was_busy && m_k == m_prev)) begin
                    m_busy  = 1'b1;
                    m_owner = m_k;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [N-1:0] e_gnt;
    logic [W-1:0] e_a;
    logic [W-1:0] e_b;
    logic [W-1:0] e_sum;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            e_gnt = '0;
            e_a   = '0;
            e_b   = '0;
            if (m_busy) begin
                e_gnt[m_owner] = 1'b1;
                e_a = op_a(m_owner);
                e_b = op_b(m_owner);
            end
            e_sum = e_a + e_b;
            check("model_gnt", bus.gnt, e_gnt);
            check("model_busy", bus.busy, m_busy);
            if (m_busy) check("model_owner", bus.owner, m_owner);
            check("model_sum_in_a", bus.sum_in_a, e_a);
            check("model_sum_in_b", bus.sum_in_b, e_b);
            check("model_result", bus.result, e_sum);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req    = '0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        rst        = 1'b1;

        // Reset state, sampled mid-cycle while reset is held
        #12;
        check("reset_gnt", bus.gnt, 3'b000);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_owner", bus.owner, 2'd0);
        check("reset_sum_in_a", bus.sum_in_a, 16'd0);
        check("reset_sum_in_b", bus.sum_in_b, 16'd0);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single client: grant after one edge, operands through, wrap
        set_ops(0, 16'd100, 16'd27);
        bus.req = 3'b001;
        step();
        check("single_gnt", bus.gnt, 3'b001);
        check("single_busy", bus.busy, 1'b1);
        check("single_sum_in_a", bus.sum_in_a, 16'd100);
        check("single_sum_in_b", bus.sum_in_b, 16'd27);
        check("single_result", bus.result, 16'd127);
        set_ops(0, 16'hFFFF, 16'd2);
        #1;
        check("single_wrap", bus.result, 16'd1);
        bus.req = 3'b000;
        step();
        check("single_rel_gnt", bus.gnt, 3'b000);
        check("single_rel_busy", bus.busy, 1'b0);
        check("single_rel_sum_in_a", bus.sum_in_a, 16'd0);

        // Tie at reset, zero-bubble handoffs, pointer back to 0
        do_reset();
        bus.req = 3'b111;
        step();
        check("tie_gnt0", bus.gnt, 3'b001);
        bus.req = 3'b110;
        step();
        check("tie_gnt1", bus.gnt, 3'b010);
        check("tie_busy1", bus.busy, 1'b1);
        bus.req = 3'b100;
        step();
        check("tie_gnt2", bus.gnt, 3'b100);
        bus.req = 3'b000;
        step();
        check("tie_idle_gnt", bus.gnt, 3'b000);
        check("tie_idle_busy", bus.busy, 1'b0);
        bus.req = 3'b111;
        step();
        check("tie_rr_wrap", bus.gnt, 3'b001);
        bus.req = 3'b000;
        step();

        // Fairness: clients 0/1 re-request with one-cycle sessions
        do_reset();
        bus.req = 3'b011;
        step();
        for (int i = 0; i < 10; i++) begin
            check("fair_busy", bus.busy, 1'b1);
            check("fair_owner", bus.owner, i % 2);
            bus.req[0] = ~bus.gnt[0];
            bus.req[1] = ~bus.gnt[1];
        step();
        end
        bus.req = 3'b000;
        step();

        // Lock: client 2 keeps the adder while everyone requests
        do_reset();
        set_ops(2, 16'h1234, 16'h0042);
        bus.req = 3'b100;
        step();
        check("lock_gnt_first", bus.gnt, 3'b100);
        bus.req = 3'b111;
        for (int i = 0; i < 50; i++) begin
            set_ops(0, W'($urandom), W'($urandom));
            set_ops(1, W'($urandom), W'($urandom));
            step();
            check("lock_gnt", bus.gnt, 3'b100);
            check("lock_sum_in_a", bus.sum_in_a, 16'h1234);
            check("lock_sum_in_b", bus.sum_in_b, 16'h0042);
        end
        bus.req = 3'b011;
        step();
        check("lock_handoff", bus.gnt, 3'b001);
        bus.req = 3'b000;
        step();

        // Asynchronous reset in the middle of a session
        do_reset();
        set_ops(1, 16'h0F0F, 16'h0101);
        bus.req = 3'b010;
        step();
        check("areset_pre_gnt", bus.gnt, 3'b010);
        #1;
        rst = 1'b1;
        #1;
        check("areset_gnt", bus.gnt, 3'b000);
        check("areset_busy", bus.busy, 1'b0);
        check("areset_sum_in_a", bus.sum_in_a, 16'd0);
        step();
        rst = 1'b0;
        step();
        check("areset_regrant", bus.gnt, 3'b010);
        bus.req = 3'b000;
        step();

        // Randomized traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(3) == 0) bus.req[k] = ~bus.req[k];
                set_ops(k, W'($urandom), W'($urandom));
            end
            if ($urandom_range(499) == 0) begin
                #1;
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        chk_en  = 1'b0;
        bus.req = '0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sum_arbiter.md
Name: sum_arbiter

Overview:
- Shares the single combinational `sum` adder (16-bit a/b in, 16-bit result out) between N sequential datapath clients, e.g. `cbrt` plus future iterative units.
- Each client requests the adder with a level `req`. The arbiter grants round-robin and holds (locks) the grant until the owner drops `req`.
- While granted, the owner's operands are muxed onto `sum_in_a`/`sum_in_b`. The adder result is broadcast back to all clients.

Parameters:
- N_CLIENTS, 3, number of requesters (2..8)
- WIDTH, 16, adder operand/result width
- IDX_W, 2, width of owner index; must satisfy 2**IDX_W >= N_CLIENTS

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N_CLIENTS  per-client request, level; held high for the whole adder session
- a_flat  input  N_CLIENTS*WIDTH  client operands A; client k occupies bits [k*WIDTH +: WIDTH]
- b_flat  input  N_CLIENTS*WIDTH  client operands B, same packing
- gnt  output  N_CLIENTS  one-hot grant, registered; all zero when no owner
- owner  output  IDX_W  index of current owner; valid only when busy=1
- busy  output  1  registered; 1 when some client owns the adder
- result  output  WIDTH  broadcast of sum_out, combinational pass-through
- sum_in_a  output  WIDTH  operand A to the adder
- sum_in_b  output  WIDTH  operand B to the adder
- sum_out  input  WIDTH  result from the adder

Behaviour:
- Reset (async, immediate on rst=1): gnt=0, busy=0, owner=0, rr_ptr=0, sum_in_a=sum_in_b=0. A grant in progress is dropped at once; the client sees gnt fall without a handshake.
- FSM states:
  - IDLE: busy=0.
  - OWNED: busy=1.
- IDLE transitions:
  - At a rising edge with req!=0, select the first k with req[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N_CLIENTS.
  - Register gnt=1<<k, owner=k, go to OWNED.
  - Grant latency: req rising before edge E -> gnt high after E (1 cycle).
- OWNED, req[owner]=1: hold gnt/owner unchanged regardless of other reqs. No preemption, no timeout.
- OWNED, edge where req[owner]=0 (release):
  - rr_ptr <= (owner+1) mod N_CLIENTS.
  - Same edge, scan the other clients starting at owner+1; the releasing client is excluded for this edge.
  - If one is found: gnt/owner move to it directly, stay in OWNED. Zero-bubble handoff.
  - Otherwise: gnt=0, go to IDLE.
- rr_ptr changes only on release, never on grant.
- Operand mux:
  - busy=1: sum_in_a = a_flat[owner*WIDTH +: WIDTH]; sum_in_b likewise from b_flat.
  - busy=0: both are 0.
  - Combinational from registered owner and the live operand bus. Clients may change operands every cycle while granted.
- result = sum_out always. Clients must qualify it with their own gnt bit. Addition wraps modulo 2**WIDTH in the adder; the arbiter adds no width changes.
- Client protocol:
  - A client must not drive operands assuming ownership before seeing gnt[k]=1.
  - Deasserting req before grant withdraws the request with no side effects.
- req bits for indices >= N_CLIENTS do not exist. gnt is strictly one-hot or zero: an invariant, checked by assertion.
- Simultaneous release by the owner and a new request from the same client at the same edge is impossible by definition (one req bit). The client re-enters arbitration on the next edge and waits behind other requesters.

Test Plan:
- Single client: reset, req=3'b001 at edge 1 -> gnt=001, busy=1 after edge 1. a=100, b=27 -> sum_in_a=100, sum_in_b=27, result=127. Drop req -> gnt=000, busy=0 after next edge.
- Tie at reset: req=3'b111 together -> gnt=001 (rr_ptr=0). Client 0 releases -> gnt=010 on the same edge with no idle cycle. Client 1 releases -> gnt=100. Client 2 releases -> IDLE, rr_ptr=0.
- Fairness: clients 0 and 1 continuously re-request with 1-cycle sessions over 10 sessions -> grants alternate 0,1,0,1... and neither client wins twice in a row while the other waits.
- Lock: client 2 owns for 50 cycles with req=3'b111 throughout -> gnt stays 100; operand bus changes on clients 0/1 never appear on sum_in_a/b.
- Async reset mid-session: assert rst between clock edges while gnt=010 -> gnt=0, busy=0, sum_in_a=0 before the next edge. After release, req=3'b010 -> grant after 1 edge.
- Integration: two `cbrt` instances sharing one `sum` via sum_arbiter, inputs 216 and 27, started together -> results 6 and 3. Each result is correct, and busy overlap causes no corruption.
